reg_write_arbiter: RTL and testbench

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter.sv | 152 +++++++++++++++
 tb/tb_reg_write_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - two-source register-file writeback arbiter with pending-write scoreboard
//
// Purpose:
//   Arbitrates between two writeback sources (A = ALU, B = memory load) for a
//   single register-file write port, registers the winning write for one
//   cycle, and tracks which destination registers have a write outstanding so
//   decode can detect read-after-write hazards.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   alloc_valid, alloc_reg    issue stage reserves a destination register
//   a_valid/a_reg/a_data      writeback request A, granted by a_ready
//   b_valid/b_reg/b_data      writeback request B, granted by b_ready
//   WriteReg/DstReg/DstData   registered register-file write port
//   src1_reg, src2_reg        read IDs being decoded
//   hazard                    a decoded read depends on a pending write
//   pending                   one bit per register with a write outstanding
//   err_waw, err_spur         sticky protocol-error flags
//
// Parameters:
//   FAIR  1 = round-robin on contention, 0 = A always wins contention

module reg_write_arbiter #(
  parameter int FAIR = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alloc_valid,
  input  logic [3:0]  alloc_reg,
  input  logic        a_valid,
  input  logic [3:0]  a_reg,
  input  logic [15:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [3:0]  b_reg,
  input  logic [15:0] b_data,
  output logic        b_ready,
  output logic        WriteReg,
  output logic [3:0]  DstReg,
  output logic [15:0] DstData,
  input  logic [3:0]  src1_reg,
  input  logic [3:0]  src2_reg,
  output logic        hazard,
  output logic [15:0] pending,
  output logic        err_waw,
  output logic        err_spur
);

  // Round-robin pointer: 1 means B won the most recent contended cycle,
  // so A gets the next one.
  logic        r_last_b;

  logic        w_contend;
  logic        w_a_ready;
  logic        w_b_ready;
  logic        w_xfer;
  logic [3:0]  w_win_reg;
  logic [15:0] w_win_data;
  logic [15:0] w_set_mask;
  logic [15:0] w_clr_mask;
  logic [15:0] w_pending_nxt;
  logic        w_waw;
  logic        w_spur;

  // Grant logic. Held at zero during reset so nothing is accepted while the
  // write port and scoreboard are being cleared.
  always_comb begin
    w_contend = a_valid & b_valid;
    w_a_ready = 1'b0;
    w_b_ready = 1'b0;
    if (!rst) begin
      if (w_contend) begin
        if ((FAIR == 0) || r_last_b) begin
          w_a_ready = 1'b1;
        end else begin
          w_b_ready = 1'b1;
        end
      end else begin
        w_a_ready = a_valid;
        w_b_ready = b_valid;
      end
    end
  end

  assign a_ready = w_a_ready;
  assign b_ready = w_b_ready;

  // Winner selection; grants are one-hot so a simple mux suffices.
  always_comb begin
    w_xfer     = w_a_ready | w_b_ready;
    w_win_reg  = w_b_ready ? b_reg  : a_reg;
    w_win_data = w_b_ready ? b_data : a_data;
  end

  // Scoreboard next state. The clear targets the write currently on the
  // register-file port; the set is OR'd in last so a same-edge re-allocation
  // of that register survives.
  always_comb begin
    w_set_mask    = alloc_valid ? (16'h0001 << alloc_reg) : 16'h0000;
    w_clr_mask    = WriteReg    ? (16'h0001 << DstReg)    : 16'h0000;
    w_pending_nxt = (pending & ~w_clr_mask) | w_set_mask;
  end

  // Protocol checks. Re-allocating a register whose write retires on this
  // same edge is legal; only a still-outstanding register is a WAW error.
  always_comb begin
    w_waw  = alloc_valid & pending[alloc_reg] &
             ~(WriteReg & (DstReg == alloc_reg));
    w_spur = WriteReg & ~pending[DstReg];
  end

  assign hazard = pending[src1_reg] | pending[src2_reg];

  // Round-robin pointer moves only when both sources competed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_b <= 1'b1;
    end else if (w_contend) begin
      r_last_b <= w_b_ready;
    end
  end

  // Registered write port. DstReg/DstData hold their last value on idle
  // cycles; only the enable drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WriteReg <= 1'b0;
      DstReg   <= 4'h0;
      DstData  <= 16'h0000;
    end else begin
      WriteReg <= w_xfer;
      if (w_xfer) begin
        DstReg  <= w_win_reg;
        DstData <= w_win_data;
      end
    end
  end

  // Scoreboard and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= 16'h0000;
      err_waw  <= 1'b0;
      err_spur <= 1'b0;
    end else begin
      pending  <= w_pending_nxt;
      err_waw  <= err_waw  | w_waw;
      err_spur <= err_spur | w_spur;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - directed scoreboard bench for reg_write_arbiter

module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alloc_valid = 1'b0;
  logic [3:0]  alloc_reg = 4'h0;
  logic        a_valid = 1'b0;
  logic [3:0]  a_reg = 4'h0;
  logic [15:0] a_data = 16'h0;
  logic        b_valid = 1'b0;
  logic [3:0]  b_reg = 4'h0;
  logic [15:0] b_data = 16'h0;
  logic [3:0]  src1_reg = 4'h0;
  logic [3:0]  src2_reg = 4'h0;

  logic        a_ready, b_ready, WriteReg, hazard, err_waw, err_spur;
  logic [3:0]  DstReg;
  logic [15:0] DstData, pending;

  logic        a_ready0, b_ready0, WriteReg0, hazard0, err_waw0, err_spur0;
  logic [3:0]  DstReg0;
  logic [15:0] DstData0, pending0;

  int          n_checks = 0;
  int          n_errors = 0;
  logic        m_last_b = 1'b1;
  logic [19:0] sb[$];

  always #5 clk = ~clk;

  reg_write_arbiter #(.FAIR(1)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_reg(alloc_reg),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
    .WriteReg(WriteReg), .DstReg(DstReg), .DstData(DstData),
    .src1_reg(src1_reg), .src2_reg(src2_reg), .hazard(hazard),
    .pending(pending), .err_waw(err_waw), .err_spur(err_spur)
  );

  reg_write_arbiter #(.FAIR(0)) dut_fixed (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_reg(alloc_reg),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready0),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready0),
    .WriteReg(WriteReg0), .DstReg(DstReg0), .DstData(DstData0),
    .src1_reg(src1_reg), .src2_reg(src2_reg), .hazard(hazard0),
    .pending(pending0), .err_waw(err_waw0), .err_spur(err_spur0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check grants against the arbitration
  // model, push the expected write, then check the registered write port.
  task automatic do_cycle(input logic av, input logic [3:0] ar, input logic [15:0] ad,
                          input logic bv, input logic [3:0] br, input logic [15:0] bd,
                          input logic alv, input logic [3:0] alr);
    logic        ea, eb, ew;
    logic [19:0] exp_w;
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
    alloc_valid = alv; alloc_reg = alr;
    #1;
    ea = av & (~bv | m_last_b);
    eb = bv & ~ea;
    chk("a_ready_rr", a_ready, ea);
    chk("b_ready_rr", b_ready, eb);
    chk("a_ready_fixed", a_ready0, av);
    chk("b_ready_fixed", b_ready0, bv & ~av);
    if (av & bv) m_last_b = eb;
    ew = ea | eb;
    if (ea) sb.push_back({ar, ad});
    else if (eb) sb.push_back({br, bd});
    @(posedge clk);
    #1;
    chk("WriteReg", WriteReg, ew);
    if (ew && sb.size() > 0) begin
      exp_w = sb.pop_front();
      chk("DstReg", DstReg, exp_w[19:16]);
      chk("DstData", DstData, exp_w[15:0]);
    end
  endtask

  task automatic idle();
    do_cycle(1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state, with requests present to confirm no grant during reset.
    #1 rst = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    chk("rst_WriteReg", WriteReg, 1'b0);
    chk("rst_DstReg", DstReg, 4'h0);
    chk("rst_DstData", DstData, 16'h0000);
    chk("rst_pending", pending, 16'h0000);
    chk("rst_err_waw", err_waw, 1'b0);
    chk("rst_err_spur", err_spur, 1'b0);
    chk("rst_a_ready", a_ready, 1'b0);
    chk("rst_b_ready", b_ready, 1'b0);
    #20;
    a_valid = 1'b0; b_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic alloc / write / clear of R5.
    do_cycle(1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b1, 4'd5);
    chk("p5_after_alloc", pending[5], 1'b1);
    do_cycle(1'b1, 4'd5, 16'hBEEF, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0);
    chk("p5_during_write", pending[5], 1'b1);
    idle();
    chk("p5_after_write", pending[5], 1'b0);
    chk("DstReg_hold", DstReg, 4'd5);
    chk("DstData_hold", DstData, 16'hBEEF);
    chk("err_spur_clean", err_spur, 1'b0);

    // Hazard via src1 and via src2.
    src1_reg = 4'd3; src2_reg = 4'd7;
    do_cycle(1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b1, 4'd3);
    chk("hazard_src1", hazard, 1'b1);
    do_cycle(1'b1, 4'd3, 16'h0333, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0);
    chk("hazard_during_write", hazard, 1'b1);
    idle();
    chk("hazard_cleared", hazard, 1'b0);
    do_cycle(1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b1, 4'd7);
    chk("hazard_src2", hazard, 1'b1);
    do_cycle(1'b0, 4'h0, 16'h0, 1'b1, 4'd7, 16'h7777, 1'b0, 4'h0);
    idle();
    chk("hazard_src2_cleared", hazard, 1'b0);
    src1_reg = 4'd0; src2_reg = 4'd0;

    // Same-edge re-allocation of R9 is legal; a second one is WAW.
    do_cycle(1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b1, 4'd9);
    do_cycle(1'b1, 4'd9, 16'h9999, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0);
    do_cycle(1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b1, 4'd9);
    chk("p9_set_wins", pending[9], 1'b1);
    chk("err_waw_legal", err_waw, 1'b0);
    do_cycle(1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b1, 4'd9);
    chk("err_waw_set", err_waw, 1'b1);
    chk("p9_stays", pending[9], 1'b1);
    idle();
    chk("err_waw_sticky", err_waw, 1'b1);

    // Spurious write from B to R4 is still performed.
    chk("p4_clear", pending[4], 1'b0);
    do_cycle(1'b0, 4'h0, 16'h0, 1'b1, 4'd4, 16'h4444, 1'b0, 4'h0);
    idle();
    chk("err_spur_set", err_spur, 1'b1);
    idle();
    chk("err_spur_sticky", err_spur, 1'b1);

    // Contended burst: A,B,A,B round-robin; fixed-priority copy always A.
    for (int i = 0; i < 4; i++)
      do_cycle(1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 1'b0, 4'h0);
    do_cycle(1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 1'b0, 4'h0);

    // Asynchronous reset mid-burst while WriteReg is high.
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_WriteReg", WriteReg, 1'b0);
    chk("mid_rst_DstReg", DstReg, 4'h0);
    chk("mid_rst_DstData", DstData, 16'h0000);
    chk("mid_rst_pending", pending, 16'h0000);
    chk("mid_rst_err_waw", err_waw, 1'b0);
    chk("mid_rst_err_spur", err_spur, 1'b0);
    chk("mid_rst_a_ready", a_ready, 1'b0);
    chk("mid_rst_b_ready", b_ready, 1'b0);
    @(posedge clk);
    #2;
    a_valid = 1'b0; b_valid = 1'b0;
    rst = 1'b0;
    m_last_b = 1'b1;
    sb.delete();
    idle();
    do_cycle(1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 1'b0, 4'h0);
    do_cycle(1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 1'b0, 4'h0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
